// File: rtl/motoro3_ramp_scheduler.sv
// Run-level controller for the 3-phase commutation block: align, period ramp,
// run, coast and fault sequencing with stall supervision and round counting.
module motoro3_ramp_scheduler #(
    parameter int unsigned CNT_W        = 25,
    parameter int unsigned START_PERIOD = 666666,
    parameter int unsigned MIN_PERIOD   = 1667,
    parameter int unsigned RAMP_DEC     = 1000,
    parameter int unsigned ALIGN_TICKS  = 100000,
    parameter int unsigned COAST_TICKS  = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [CNT_W-1:0] target_period,
    input  logic             fault_in,
    input  logic             step_tick,
    output logic             m3start,
    output logic             align_active,
    output logic [CNT_W-1:0] m3period,
    output logic [2:0]       state,
    output logic             at_speed,
    output logic [1:0]       fault_code,
    output logic [15:0]      round_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_COAST = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] START_P   = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] DEC_P     = CNT_W'(RAMP_DEC);
    localparam logic [CNT_W-1:0] ALIGN_LD  = CNT_W'(ALIGN_TICKS - 1);
    localparam logic [CNT_W-1:0] COAST_LD  = CNT_W'(COAST_TICKS - 1);
    localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   WD_ONE    = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   DEC_W     = (CNT_W+1)'(RAMP_DEC);

    state_t           st;
    logic [CNT_W-1:0] tmr;
    logic [CNT_W:0]   wd;
    logic [2:0]       step_ph;

    logic [CNT_W-1:0] tgt_eff;
    logic [CNT_W-1:0] per_step;
    logic [CNT_W:0]   per_w;
    logic [CNT_W:0]   tgt_w;
    logic [CNT_W:0]   stall_lim;
    logic             run_phase;
    logic             stall_hit;

    assign state     = st;
    assign per_w     = {1'b0, m3period};
    assign tgt_w     = {1'b0, tgt_eff};
    assign stall_lim = {m3period, 1'b0};
    assign run_phase = (st == S_RAMP) || (st == S_RUN);
    assign stall_hit = run_phase && (wd >= stall_lim);

    always_comb begin
        tgt_eff = target_period;
        if (target_period < MIN_P)
            tgt_eff = MIN_P;
        else if (target_period > START_P)
            tgt_eff = START_P;
    end

    // Comparisons are done one bit wider so neither direction can wrap.
    always_comb begin
        per_step = tgt_eff;
        if (per_w > tgt_w + DEC_W)
            per_step = m3period - DEC_P;
        else if (per_w + DEC_W < tgt_w)
            per_step = CNT_W'(per_w + DEC_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= S_IDLE;
            m3start      <= 1'b0;
            align_active <= 1'b0;
            at_speed     <= 1'b0;
            fault_code   <= 2'd0;
            round_cnt    <= '0;
            m3period     <= START_P;
            tmr          <= '0;
            wd           <= '0;
            step_ph      <= '0;
        end else if (st != S_FAULT && fault_in) begin
            st           <= S_FAULT;
            fault_code   <= 2'd1;
            m3start      <= 1'b0;
            align_active <= 1'b0;
            at_speed     <= 1'b0;
            wd           <= '0;
            tmr          <= '0;
        end else if (stall_hit) begin
            st           <= S_FAULT;
            fault_code   <= 2'd2;
            m3start      <= 1'b0;
            align_active <= 1'b0;
            at_speed     <= 1'b0;
            wd           <= '0;
        end else if (cmd_stop && (st == S_ALIGN || run_phase)) begin
            st           <= S_COAST;
            m3start      <= 1'b0;
            align_active <= 1'b0;
            at_speed     <= 1'b0;
            tmr          <= COAST_LD;
            wd           <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (cmd_start && !cmd_stop) begin
                        st           <= S_ALIGN;
                        align_active <= 1'b1;
                        tmr          <= ALIGN_LD;
                        round_cnt    <= '0;
                        step_ph      <= '0;
                        m3period     <= START_P;
                    end
                end
                S_ALIGN: begin
                    if (tmr == '0) begin
                        st           <= S_RAMP;
                        m3start      <= 1'b1;
                        align_active <= 1'b0;
                        wd           <= '0;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                S_RAMP, S_RUN: begin
                    if (step_tick) begin
                        wd <= '0;
                        if (step_ph == 3'd5) begin
                            step_ph <= '0;
                            if (round_cnt != 16'hFFFF)
                                round_cnt <= round_cnt + 16'd1;
                        end else begin
                            step_ph <= step_ph + 3'd1;
                        end
                        // RUN leaves for RAMP on any target change, even a single-step one.
                        if (!(st == S_RUN && m3period == tgt_eff)) begin
                            m3period <= per_step;
                            if (st == S_RAMP && per_step == tgt_eff) begin
                                st       <= S_RUN;
                                at_speed <= 1'b1;
                            end else begin
                                st       <= S_RAMP;
                                at_speed <= 1'b0;
                            end
                        end
                    end else begin
                        wd <= wd + WD_ONE;
                    end
                end
                S_COAST: begin
                    if (tmr == '0) begin
                        st       <= S_IDLE;
                        m3period <= START_P;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                S_FAULT: begin
                    if (cmd_stop && !fault_in) begin
                        st         <= S_IDLE;
                        fault_code <= 2'd0;
                        m3period   <= START_P;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motoro3_ramp_scheduler.sv
// Self-checking bench for motoro3_ramp_scheduler: scenario tasks plus randomized
// ramp targets checked against a step-rule reference model.
module tb_motoro3_ramp_scheduler;

    localparam int CNT_W = 25;
    localparam int START = 100;
    localparam int MINP  = 10;
    localparam int DEC   = 20;
    localparam int ALIGN = 10;
    localparam int COAST = 5;

    localparam int ST_IDLE  = 0;
    localparam int ST_ALIGN = 1;
    localparam int ST_RAMP  = 2;
    localparam int ST_RUN   = 3;
    localparam int ST_COAST = 4;
    localparam int ST_FAULT = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_start;
    logic             cmd_stop;
    logic [CNT_W-1:0] target_period;
    logic             fault_in;
    logic             step_tick;
    logic             m3start;
    logic             align_active;
    logic [CNT_W-1:0] m3period;
    logic [2:0]       state;
    logic             at_speed;
    logic [1:0]       fault_code;
    logic [15:0]      round_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_p;
    int exp_st;
    int exp_ticks;

    motoro3_ramp_scheduler #(
        .CNT_W(CNT_W),
        .START_PERIOD(START),
        .MIN_PERIOD(MINP),
        .RAMP_DEC(DEC),
        .ALIGN_TICKS(ALIGN),
        .COAST_TICKS(COAST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_start(cmd_start),
        .cmd_stop(cmd_stop),
        .target_period(target_period),
        .fault_in(fault_in),
        .step_tick(step_tick),
        .m3start(m3start),
        .align_active(align_active),
        .m3period(m3period),
        .state(state),
        .at_speed(at_speed),
        .fault_code(fault_code),
        .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int clamp_t(input int t);
        if (t < MINP) return MINP;
        if (t > START) return START;
        return t;
    endfunction

    function automatic int ramp_next(input int p, input int t);
        if (p > t) return (p - DEC > t) ? p - DEC : t;
        return (p + DEC < t) ? p + DEC : t;
    endfunction

    task automatic do_reset();
        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; fault_in = 1'b0; step_tick = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic begin_run();
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cyc(ALIGN);
        exp_p = START; exp_st = ST_RAMP; exp_ticks = 0;
    endtask

    // Drives one step_tick after gap-1 idle cycles and advances the reference.
    task automatic do_tick(input int gap);
        int  t;
        logic was_run;
        if (gap > 1) cyc(gap - 1);
        step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
        t = clamp_t(int'(target_period));
        exp_ticks++;
        if (!(exp_st == ST_RUN && exp_p == t)) begin
            was_run = (exp_st == ST_RUN);
            exp_p   = ramp_next(exp_p, t);
            exp_st  = (!was_run && exp_p == t) ? ST_RUN : ST_RAMP;
        end
    endtask

    task automatic test_reset();
        target_period = CNT_W'(50);
        do_reset();
        n_checks++; if (state !== 3'd0) begin n_fails++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++; if (m3start !== 1'b0) begin n_fails++; $display("FAIL reset_m3start got %0b want 0", m3start); end
        n_checks++; if (align_active !== 1'b0) begin n_fails++; $display("FAIL reset_align got %0b want 0", align_active); end
        n_checks++; if (at_speed !== 1'b0) begin n_fails++; $display("FAIL reset_at_speed got %0b want 0", at_speed); end
        n_checks++; if (fault_code !== 2'd0) begin n_fails++; $display("FAIL reset_fault_code got %0d want 0", fault_code); end
        n_checks++; if (round_cnt !== 16'd0) begin n_fails++; $display("FAIL reset_round_cnt got %0d want 0", round_cnt); end
        n_checks++; if (m3period !== CNT_W'(START)) begin n_fails++; $display("FAIL reset_m3period got %0d want %0d", m3period, START); end
    endtask

    task automatic test_basic();
        int seq[3] = '{80, 60, 40};
        target_period = CNT_W'(40);
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        for (int i = 0; i < ALIGN; i++) begin
            n_checks++; if ({state, align_active, m3start} !== {3'd1, 1'b1, 1'b0}) begin n_fails++; $display("FAIL basic_align cycle %0d got state=%0d align=%0b start=%0b want 1/1/0", i, state, align_active, m3start); end
            cyc(1);
        end
        n_checks++; if ({state, align_active, m3start} !== {3'd2, 1'b0, 1'b1}) begin n_fails++; $display("FAIL basic_ramp_entry got state=%0d align=%0b start=%0b want 2/0/1", state, align_active, m3start); end
        exp_p = START; exp_st = ST_RAMP; exp_ticks = 0;
        for (int i = 0; i < 3; i++) begin
            do_tick(exp_p);
            n_checks++; if (m3period !== CNT_W'(seq[i])) begin n_fails++; $display("FAIL basic_period tick %0d got %0d want %0d", i, m3period, seq[i]); end
            n_checks++; if (state !== ((i == 2) ? 3'd3 : 3'd2)) begin n_fails++; $display("FAIL basic_state tick %0d got %0d want %0d", i, state, (i == 2) ? 3 : 2); end
            n_checks++; if (at_speed !== (i == 2)) begin n_fails++; $display("FAIL basic_at_speed tick %0d got %0b want %0b", i, at_speed, i == 2); end
        end
    endtask

    task automatic test_clamp_rounds();
        target_period = CNT_W'($urandom_range(0, MINP - 1));
        for (int i = 0; i < 9; i++) begin
            do_tick($urandom_range(1, exp_p));
            n_checks++; if (m3period !== CNT_W'(exp_p)) begin n_fails++; $display("FAIL clamp_period tick %0d got %0d want %0d", exp_ticks, m3period, exp_p); end
            n_checks++; if (state !== 3'(exp_st)) begin n_fails++; $display("FAIL clamp_state tick %0d got %0d want %0d", exp_ticks, state, exp_st); end
            n_checks++; if (round_cnt !== 16'(exp_ticks / 6)) begin n_fails++; $display("FAIL clamp_rounds tick %0d got %0d want %0d", exp_ticks, round_cnt, exp_ticks / 6); end
        end
        n_checks++; if (m3period !== CNT_W'(MINP)) begin n_fails++; $display("FAIL clamp_floor got %0d want %0d", m3period, MINP); end
        n_checks++; if (round_cnt !== 16'd2) begin n_fails++; $display("FAIL clamp_12_ticks got %0d want 2", round_cnt); end
    endtask

    task automatic test_slowdown();
        target_period = CNT_W'(40);
        for (int i = 0; i < 10 && !(exp_st == ST_RUN && exp_p == 40); i++) do_tick(exp_p);
        n_checks++; if ({state, m3period} !== {3'd3, CNT_W'(40)}) begin n_fails++; $display("FAIL slow_run40 got state=%0d period=%0d want 3/40", state, m3period); end
        target_period = CNT_W'(75);
        do_tick(40);
        n_checks++; if ({state, m3period, at_speed} !== {3'd2, CNT_W'(60), 1'b0}) begin n_fails++; $display("FAIL slow_first got state=%0d period=%0d at_speed=%0b want 2/60/0", state, m3period, at_speed); end
        do_tick(60);
        n_checks++; if ({state, m3period, at_speed} !== {3'd3, CNT_W'(75), 1'b1}) begin n_fails++; $display("FAIL slow_second got state=%0d period=%0d at_speed=%0b want 3/75/1", state, m3period, at_speed); end
    endtask

    task automatic test_stop_coast();
        target_period = CNT_W'(15);
        do_tick(75);
        n_checks++; if ({state, m3period} !== {3'd2, CNT_W'(55)}) begin n_fails++; $display("FAIL coast_pre got state=%0d period=%0d want 2/55", state, m3period); end
        cmd_stop = 1'b1;
        cyc(1);
        cmd_stop = 1'b0;
        n_checks++; if ({state, m3start, at_speed} !== {3'd4, 1'b0, 1'b0}) begin n_fails++; $display("FAIL coast_entry got state=%0d start=%0b at_speed=%0b want 4/0/0", state, m3start, at_speed); end
        cmd_start = 1'b1;
        for (int i = 1; i < COAST; i++) begin
            step_tick = (i == 2);
            cyc(1);
            step_tick = 1'b0;
            n_checks++; if ({state, m3period} !== {3'd4, CNT_W'(55)}) begin n_fails++; $display("FAIL coast_hold cycle %0d got state=%0d period=%0d want 4/55", i, state, m3period); end
        end
        cmd_start = 1'b0;
        cyc(1);
        n_checks++; if ({state, m3period, m3start} !== {3'd0, CNT_W'(START), 1'b0}) begin n_fails++; $display("FAIL coast_idle got state=%0d period=%0d start=%0b want 0/%0d/0", state, m3period, m3start, START); end
    endtask

    task automatic test_stall();
        begin_run();
        target_period = CNT_W'(40);
        do_tick(100); do_tick(80); do_tick(60);
        n_checks++; if ({state, m3period} !== {3'd3, CNT_W'(40)}) begin n_fails++; $display("FAIL stall_pre got state=%0d period=%0d want 3/40", state, m3period); end
        cyc(80);
        n_checks++; if (state !== 3'd3) begin n_fails++; $display("FAIL stall_early got state=%0d want 3", state); end
        cyc(1);
        n_checks++; if ({state, fault_code, m3start, at_speed} !== {3'd5, 2'd2, 1'b0, 1'b0}) begin n_fails++; $display("FAIL stall_fault got state=%0d code=%0d start=%0b at_speed=%0b want 5/2/0/0", state, fault_code, m3start, at_speed); end
        fault_in = 1'b1;
        cyc(1);
        n_checks++; if ({state, fault_code} !== {3'd5, 2'd2}) begin n_fails++; $display("FAIL stall_hold got state=%0d code=%0d want 5/2", state, fault_code); end
        cmd_stop = 1'b1;
        cyc(1);
        n_checks++; if (state !== 3'd5) begin n_fails++; $display("FAIL stall_stop_blocked got state=%0d want 5", state); end
        fault_in = 1'b0;
        cyc(1);
        cmd_stop = 1'b0;
        n_checks++; if ({state, fault_code, m3period} !== {3'd0, 2'd0, CNT_W'(START)}) begin n_fails++; $display("FAIL stall_recover got state=%0d code=%0d period=%0d want 0/0/%0d", state, fault_code, m3period, START); end
    endtask

    task automatic test_simultaneous();
        cmd_start = 1'b1; cmd_stop = 1'b1;
        cyc(3);
        cmd_start = 1'b0; cmd_stop = 1'b0;
        n_checks++; if ({state, align_active} !== {3'd0, 1'b0}) begin n_fails++; $display("FAIL sim_start_stop got state=%0d align=%0b want 0/0", state, align_active); end
        begin_run();
        target_period = CNT_W'(60);
        do_tick(100); do_tick(80);
        fault_in = 1'b1; cmd_stop = 1'b1;
        cyc(1);
        n_checks++; if ({state, fault_code, m3start, at_speed} !== {3'd5, 2'd1, 1'b0, 1'b0}) begin n_fails++; $display("FAIL sim_fault_stop got state=%0d code=%0d start=%0b at_speed=%0b want 5/1/0/0", state, fault_code, m3start, at_speed); end
        fault_in = 1'b0;
        cyc(1);
        cmd_stop = 1'b0;
        begin_run();
        target_period = CNT_W'(0);
        for (int i = 0; i < 6; i++) do_tick(exp_p);
        target_period = CNT_W'(START);
        do_tick(exp_p);
        n_checks++; if ({state, m3period, round_cnt} !== {3'd2, CNT_W'(30), 16'd1}) begin n_fails++; $display("FAIL sim_pre_rst got state=%0d period=%0d rounds=%0d want 2/30/1", state, m3period, round_cnt); end
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        n_checks++; if ({state, m3start, align_active, at_speed, fault_code, round_cnt, m3period} !== {3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, CNT_W'(START)}) begin n_fails++; $display("FAIL sim_mid_rst got state=%0d start=%0b align=%0b at=%0b code=%0d rounds=%0d period=%0d", state, m3start, align_active, at_speed, fault_code, round_cnt, m3period); end
    endtask

    task automatic test_random_targets();
        begin_run();
        for (int r = 0; r < 8; r++) begin
            target_period = CNT_W'($urandom_range(0, 130));
            for (int i = 0; i < 12; i++) begin
                do_tick($urandom_range(1, exp_p));
                n_checks++; if ({state, m3period} !== {3'(exp_st), CNT_W'(exp_p)}) begin n_fails++; $display("FAIL rand_step r%0d i%0d got state=%0d period=%0d want %0d/%0d", r, i, state, m3period, exp_st, exp_p); end
                n_checks++; if ({at_speed, round_cnt} !== {exp_st == ST_RUN, 16'(exp_ticks / 6)}) begin n_fails++; $display("FAIL rand_flags r%0d i%0d got at_speed=%0b rounds=%0d want %0b/%0d", r, i, at_speed, round_cnt, exp_st == ST_RUN, exp_ticks / 6); end
                if (exp_st == ST_RUN) break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp_rounds();
        test_slowdown();
        test_stop_coast();
        test_stall();
        test_simultaneous();
        test_random_targets();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fails++;
        $display("FAIL timeout simulation exceeded time budget");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
